slt_share_arbiter: RTL and testbench
====================================

# slt_share_arbiter

Time-shares one 32-bit less-than comparator among NREQ pipeline requesters (EX-stage SLT/SLTU, branch-compare unit, trap/bounds checker). Each requester presents operands on a valid/ready port. A round-robin arbiter grants one request per cycle. The block returns a registered 32-bit flag (1 or 0) tagged with the requester index. It sits beside the EX stage, between requesters and the single compare datapath.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- W, default 32: operand and flag width.
- IDW, default 2: response tag width, $clog2(NREQ).
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous, active-low reset.
- req_valid  input  NREQ: request i pending.
- req_a  input  NREQ*W: operand a of requester i in bits [i*W +: W].
- req_b  input  NREQ*W: operand b, packed the same way.
- req_signed  input  NREQ: 1 selects a two's-complement compare, 0 an unsigned compare.
- req_ready  output  NREQ: one-hot grant; request i is accepted when req_valid[i] && req_ready[i].
- rsp_valid  output  1: result register holds a result.
- rsp_id  output  IDW: index of the requester that produced the result.
- rsp_flag  output  W: 32'd1 if a<b, else 32'd0.
- rsp_ready  input  1: consumer accepts the response.

## Operation
- **Compare rule.**
  - Unsigned: flag = (a < b).
  - Signed: flag = (a[W-1] != b[W-1]) ? a[W-1] : (a < b).
  - The upper W-1 bits of rsp_flag are always 0.
- **Output slot.** There is a single output slot. `slot_free = !rsp_valid || rsp_ready`.
- **Grant.**
  - When slot_free, grant the first i with req_valid[i], searching cyclically from rr_ptr.
  - req_ready is one-hot or zero, combinational from req_valid, rr_ptr and slot_free.
  - When !slot_free, req_ready = 0 (all bits).
- **On accept (posedge).**
  - rsp_valid ← 1.
  - rsp_id ← i.
  - rsp_flag ← compare(req_a[i], req_b[i], req_signed[i]).
  - rr_ptr ← (i+1) mod NREQ.
- **Consume without new grant.** rsp_valid ← 0. rsp_id and rsp_flag hold their last values.
- **No requests.** rr_ptr is unchanged and no state changes.
- **Simultaneous consume and grant.** The register reloads in the same edge, so back-to-back throughput is 1 result per cycle.
- **Requester rules.**
  - A requester keeps valid and operands stable until accepted.
  - Dropping valid before acceptance is allowed; no state is left behind.
- **Fairness.** With all NREQ requesting continuously and rsp_ready = 1, each requester is granted once per NREQ cycles.
- **Reset.**
  - rst_n low clears rsp_valid, rsp_id, rsp_flag and rr_ptr to 0 immediately, from any state.
  - A pending or held result is discarded; requesters re-present.
  - req_ready is 0 while rst_n is low.

## Timing
- Latency: accept at edge N; rsp_valid/rsp_id/rsp_flag are visible after edge N, in the cycle N+1.
- Throughput: 1 compare per cycle while rsp_ready = 1.
- Backpressure: with rsp_ready = 0, the response holds its value and all req_ready drop in the same cycle.
- Combinational paths:
  - req_valid → req_ready.
  - rsp_ready → req_ready.
  - No combinational path from req_a/req_b to any output.
- Compare plus operand mux must fit in one cycle at the CPU clock. No internal pipelining.

## Structure
- Shared package `cmp_pkg`:
  - W = 32.
  - The cmp_op_t enum {CMP_UNSIGNED, CMP_SIGNED}, also used by the decoder.
  - The FLAG_TRUE/FLAG_FALSE constants (32'd1/32'd0).
- Sub-module `cmp_lt`: combinational signed/unsigned less-than. Ports a, b, is_signed, lt. Instantiated once after the operand mux.
- Arbiter logic is a rotate-priority-rotate back scheme, kept inline.

## Test plan
- **Reset mid-stall.** Hold rsp_ready = 0 with rsp_valid = 1, then pulse rst_n low → rsp_valid = 0, rr_ptr = 0, and req_ready = 0 during reset.
- **Single unsigned request.** req 0: a = 32'h0000_0001, b = 32'hFFFF_FFFF, unsigned → one cycle later rsp_valid = 1, rsp_id = 0, rsp_flag = 32'd1.
- **Single signed request.** Same operands on req 2, signed → rsp_id = 2, rsp_flag = 32'd0. Then a = 32'h8000_0000, b = 0, signed → rsp_flag = 32'd1. Equal operands → 32'd0.
- **Round robin.** All 4 valid continuously, rsp_ready = 1 → grant order 0,1,2,3,0,… with one rsp_valid per cycle and no gaps.
- **Backpressure.** rsp_ready = 0 for 3 cycles with 2 requests pending → response held stable and req_ready = 0. Raise rsp_ready → the next grant is accepted on the same edge as the consume.
- **Sparse and dropped requests.** Only req 3 valid while rr_ptr = 1 → req 3 granted and rr_ptr → 0. A request dropped before grant → no response is produced for it.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared compare types and constants for the EX-stage compare users.
// Exports W, cmp_op_t, FLAG_TRUE and FLAG_FALSE.
package cmp_pkg;

  localparam int W = 32;

  typedef enum logic {
    CMP_UNSIGNED = 1'b0,
    CMP_SIGNED   = 1'b1
  } cmp_op_t;

  localparam logic [W-1:0] FLAG_TRUE  = 32'd1;
  localparam logic [W-1:0] FLAG_FALSE = 32'd0;

endpackage

// File: rtl/cmp_lt.sv
// Combinational signed/unsigned less-than.
// Ports: a, b operands; is_signed selects two's complement; lt result.
module cmp_lt #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_signed,
  output logic         lt
);

  logic ult;
  logic sdiff;

  assign ult   = a < b;
  assign sdiff = a[W-1] != b[W-1];

  // Differing signs: the negative operand is the smaller one.
  assign lt = (is_signed && sdiff) ? a[W-1] : ult;

endmodule

// File: rtl/slt_share_arbiter.sv
// Round-robin share of one less-than comparator among NREQ requesters.
// Ports: req_* valid/ready request side, rsp_* registered result side.
module slt_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0] req_signed,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_flag,
  input  logic            rsp_ready
);

  import cmp_pkg::*;

  localparam logic [IDW:0] NR = (IDW+1)'(NREQ);

  logic [IDW-1:0]  rr_ptr;
  logic            slot_free;
  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  k;
  logic            hit;
  logic [IDW:0]    sum;
  logic [IDW-1:0]  gidx;
  logic            accept;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  cmp_op_t         op;
  logic            lt;

  assign slot_free = !rsp_valid || rsp_ready;

  // Rotate so rr_ptr sits at bit 0, pick lowest, rotate index back.
  always_comb begin
    rot = '0;
    for (int j = 0; j < NREQ; j++) begin
      int idx;
      idx = j + int'(rr_ptr);
      if (idx >= NREQ) idx = idx - NREQ;
      rot[j] = req_valid[idx];
    end
    hit = 1'b0;
    k   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        hit = 1'b1;
        k   = IDW'(j);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, k};
    if (sum >= NR) sum = sum - NR;
    gidx = sum[IDW-1:0];
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && slot_free && hit) req_ready[gidx] = 1'b1;
  end

  assign accept = |req_ready;

  assign a_sel = req_a[int'(gidx)*W +: W];
  assign b_sel = req_b[int'(gidx)*W +: W];
  assign op    = req_signed[gidx] ? CMP_SIGNED : CMP_UNSIGNED;

  cmp_lt #(.W(W)) u_lt (
    .a         (a_sel),
    .b         (b_sel),
    .is_signed (op == CMP_SIGNED),
    .lt        (lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_flag  <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gidx;
      rsp_flag  <= lt ? W'(FLAG_TRUE) : W'(FLAG_FALSE);
      if (gidx == IDW'(NREQ - 1)) rr_ptr <= '0;
      else rr_ptr <= gidx + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slt_share_arbiter.sv
// Directed plus random bench for slt_share_arbiter.
// Reference model: queue-free slot + pointer with $signed compares.
module tb_slt_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_signed;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_flag;
  logic              rsp_ready;

  slt_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_flag   (rsp_flag),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int          m_ptr;
  bit          m_v;
  int          m_id;
  logic [31:0] m_flag;
  int          last_g;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] m_cmp(logic [31:0] a,
                                        logic [31:0] b,
                                        bit s);
    if (s) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    return (a < b) ? 32'd1 : 32'd0;
  endfunction

  function automatic int m_grant();
    if (m_v && !rsp_ready) return -1;
    for (int n = 0; n < NREQ; n++) begin
      int i;
      i = (m_ptr + n) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr  = 0;
    m_v    = 0;
    m_id   = 0;
    m_flag = 0;
  endtask

  task automatic set_req(int i, logic [31:0] a,
                         logic [31:0] b, bit s);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_signed[i]   = s;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle();
    int g;
    logic [31:0] er;
    logic [31:0] ef;
    #1;
    g  = m_grant();
    er = (g >= 0) ? (32'd1 << g) : 32'd0;
    if (g >= 0)
      ef = m_cmp(req_a[g*W +: W], req_b[g*W +: W], req_signed[g]);
    else
      ef = 32'd0;
    chk("req_ready", 32'(req_ready), er);
    @(posedge clk);
    if (g >= 0) begin
      m_v    = 1;
      m_id   = g;
      m_flag = ef;
      m_ptr  = (g + 1) % NREQ;
    end else if (rsp_ready) begin
      m_v = 0;
    end
    last_g = g;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_v));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_flag", rsp_flag, m_flag);
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    rsp_ready  = 1'b1;
    last_g     = -1;
    m_reset();

    // Reset state, with requests pending.
    repeat (2) @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_flag", rsp_flag, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single unsigned on req 0.
    set_req(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    chk("u0_id", 32'(rsp_id), 32'd0);
    chk("u0_flag", rsp_flag, 32'd1);
    cycle();

    // Sparse: only req 3 with pointer at 1.
    set_req(3, 32'd5, 32'd7, 1'b0);
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    chk("sp_id", 32'(rsp_id), 32'd3);

    // Signed cases on req 2; pointer now 0.
    set_req(2, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    req_valid = 4'b0100;
    cycle();
    chk("s2_id", 32'(rsp_id), 32'd2);
    chk("s2_flag", rsp_flag, 32'd0);
    set_req(2, 32'h8000_0000, 32'h0, 1'b1);
    cycle();
    chk("s2_neg", rsp_flag, 32'd1);
    set_req(2, 32'h1234_5678, 32'h1234_5678, 1'b1);
    cycle();
    chk("s2_eq", rsp_flag, 32'd0);
    req_valid = '0;
    cycle();

    // Backpressure with reqs 0 and 1 pending; pointer at 3.
    set_req(0, 32'd9, 32'd3, 1'b0);
    set_req(1, 32'hFFFF_FFF0, 32'd2, 1'b1);
    req_valid = 4'b0011;
    cycle();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("bp_hold_id", 32'(rsp_id), 32'd0);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_next_id", 32'(rsp_id), 32'd1);
    chk("bp_next_flag", rsp_flag, 32'd1);
    chk("bp_valid", 32'(rsp_valid), 32'd1);

    // Reset while stalled with a held result.
    req_valid = 4'b0101;
    rsp_ready = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mrst_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd0);
    chk("mrst_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    // Round robin, all requesting; pointer back at 0.
    for (int i = 0; i < NREQ; i++)
      set_req(i, $urandom, $urandom, 1'($urandom));
    req_valid = 4'hF;
    for (int n = 0; n < 8; n++) begin
      cycle();
      chk("rr_id", 32'(rsp_id), 32'(n % NREQ));
      chk("rr_valid", 32'(rsp_valid), 32'd1);
    end
    req_valid = '0;
    cycle();

    // Dropped before grant: stall, present req 1, withdraw it.
    req_valid = 4'b0001;
    cycle();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle();
    chk("drop_valid", 32'(rsp_valid), 32'd0);
    cycle();

    // Random traffic honouring the requester rules.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && last_g != i) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          logic [31:0] a;
          logic [31:0] b;
          a = $urandom;
          case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ 32'h8000_0000;
            default: b = $urandom;
          endcase
          set_req(i, a, b, 1'($urandom));
          req_valid[i] = 1'b1;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
